// File: rtl/alu_seq_if.sv
// alu_seq_if: command/result handshake bundle for alu_seq.
// slave = ALU side, master = command source / result consumer side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_opcode;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic [WIDTH-1:0] o_result_hi;
    logic             o_carry;
    logic             o_zero;
    logic             o_neg;
    logic             o_ovf;
    logic             o_err;

    modport slave (
        input  i_valid, i_opcode, i_a, i_b, i_ready,
        output o_ready, o_valid, o_result, o_result_hi,
        output o_carry, o_zero, o_neg, o_ovf, o_err
    );

    modport master (
        output i_valid, i_opcode, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_result, o_result_hi,
        input  o_carry, o_zero, o_neg, o_ovf, o_err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered 8-op ALU with valid/ready on both sides.
// Macro ALU_SEQ_MUL_EN enables the iterative shift-add multiplier (opcode 7).
module alu_seq #(
    parameter int WIDTH = 8
) (
    input logic      i_clk,
    input logic      i_rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_e;

    assign sh    = bus.i_b[SHW-1:0];
    assign add_w = {1'b0, bus.i_a} + {1'b0, bus.i_b};
    assign sub_w = {1'b0, bus.i_a} - {1'b0, bus.i_b};
    // Extra bit above/below catches the last bit shifted out.
    assign shl_w = {1'b0, bus.i_a} << sh;
    assign shr_w = {bus.i_a, 1'b0} >> sh;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] step_acc;

    // acc holds {partial product, remaining multiplier bits}.
    assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign step_acc = {step_sum, acc_q[WIDTH-1:1]};
`endif

    // Single-cycle operation results from the live command inputs.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        case (bus.i_opcode)
            OP_ADD: begin
                {alu_c, alu_res} = add_w;
                alu_v = (bus.i_a[WIDTH-1] == bus.i_b[WIDTH-1])
                     && (add_w[WIDTH-1] != bus.i_a[WIDTH-1]);
            end
            OP_SUB: begin
                {alu_c, alu_res} = sub_w;
                alu_v = (bus.i_a[WIDTH-1] != bus.i_b[WIDTH-1])
                     && (sub_w[WIDTH-1] != bus.i_a[WIDTH-1]);
            end
            OP_AND: alu_res = bus.i_a & bus.i_b;
            OP_OR:  alu_res = bus.i_a | bus.i_b;
            OP_XOR: alu_res = bus.i_a ^ bus.i_b;
            OP_SHL: {alu_c, alu_res} = shl_w;
            OP_SHR: {alu_res, alu_c} = shr_w;
            OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                alu_e = 1'b0;
`else
                alu_e = 1'b1;
`endif
            end
            default: alu_e = 1'b0;
        endcase
    end

    // Next-state and next output register values.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (bus.i_opcode == OP_MUL) begin
                        mcand_d = bus.i_a;
                        acc_d   = {{WIDTH{1'b0}}, bus.i_b};
                        cnt_d   = SHW'(WIDTH - 1);
                        state_d = BUSY;
                    end else begin
`else
                    begin
`endif
                        res_d   = alu_res;
                        hi_d    = '0;
                        carry_d = alu_c;
                        zero_d  = (alu_res == '0);
                        neg_d   = alu_res[WIDTH-1];
                        ovf_d   = alu_v;
                        err_d   = alu_e;
                        state_d = DONE;
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    res_d   = step_acc[WIDTH-1:0];
                    hi_d    = step_acc[2*WIDTH-1:WIDTH];
                    carry_d = |step_acc[2*WIDTH-1:WIDTH];
                    zero_d  = (step_acc[WIDTH-1:0] == '0);
                    neg_d   = step_acc[WIDTH-1];
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything, even mid-multiply.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.o_ready     = (state_q == IDLE);
    assign bus.o_valid     = (state_q == DONE);
    assign bus.o_result    = res_q;
    assign bus.o_result_hi = hi_q;
    assign bus.o_carry     = carry_q;
    assign bus.o_zero      = zero_q;
    assign bus.o_neg       = neg_q;
    assign bus.o_ovf       = ovf_q;
    assign bus.o_err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + random checks of alu_seq (WIDTH=4)
// against an arithmetic reference model.
module tb_alu_seq;
    localparam int W    = 4;
    localparam int FULL = 1 << W;
    localparam int HALF = 1 << (W - 1);
    localparam int SMOD = 1 << $clog2(W);
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int op, input int a, input int b,
                         output int r, output int hi, output int c,
                         output int z, output int n, output int v,
                         output int e);
        int sa, sb, s, t;
        sa = (a >= HALF) ? a - FULL : a;
        sb = (b >= HALF) ? b - FULL : b;
        s  = b % SMOD;
        r = 0; hi = 0; c = 0; v = 0; e = 0;
        case (op)
            0: begin
                t = a + b;
                r = t % FULL;
                c = (t >= FULL) ? 1 : 0;
                t = sa + sb;
                v = (t >= HALF || t < -HALF) ? 1 : 0;
            end
            1: begin
                r = (a - b + FULL) % FULL;
                c = (a < b) ? 1 : 0;
                t = sa - sb;
                v = (t >= HALF || t < -HALF) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                t = a << s;
                r = t % FULL;
                c = (t >> W) & 1;
            end
            6: begin
                r = a >> s;
                c = (s > 0) ? ((a >> (s - 1)) & 1) : 0;
            end
            default: begin
                if (MUL_ON) begin
                    t  = a * b;
                    r  = t % FULL;
                    hi = t / FULL;
                    c  = (hi != 0) ? 1 : 0;
                end else begin
                    e = 1;
                end
            end
        endcase
        z = (r == 0) ? 1 : 0;
        n = (r >= HALF) ? 1 : 0;
    endtask

    task automatic chk_outs(input string p, input int r, input int hi,
                            input int c, input int z, input int n,
                            input int v, input int e);
        chk({p, "_res"},   bus.o_result,    r);
        chk({p, "_hi"},    bus.o_result_hi, hi);
        chk({p, "_carry"}, bus.o_carry,     c);
        chk({p, "_zero"},  bus.o_zero,      z);
        chk({p, "_neg"},   bus.o_neg,       n);
        chk({p, "_ovf"},   bus.o_ovf,       v);
        chk({p, "_err"},   bus.o_err,       e);
    endtask

    // Issue one command, check latency, results, stall, and release.
    task automatic run_op(input string p, input int op, input int a,
                          input int b, input int hold);
        int r, hi, c, z, n, v, e;
        int lat, wt, exp_lat;
        bit rdy_bad;
        model(op, a, b, r, hi, c, z, n, v, e);
        exp_lat = (op == 7 && MUL_ON) ? W + 1 : 1;
        wt = 0;
        while (!bus.o_ready && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        chk({p, "_ready_in"}, bus.o_ready, 1);
        bus.i_valid  = 1'b1;
        bus.i_opcode = 3'(op);
        bus.i_a      = W'(a);
        bus.i_b      = W'(b);
        lat = 0;
        rdy_bad = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            bus.i_valid = 1'b0;
            bus.i_a     = W'($urandom);
            bus.i_b     = W'($urandom);
            if (!bus.o_valid && bus.o_ready) rdy_bad = 1'b1;
        end while (!bus.o_valid && lat < 50);
        chk({p, "_latency"}, lat, exp_lat);
        chk({p, "_busy_ready"}, rdy_bad, 0);
        chk({p, "_ready_done"}, bus.o_ready, 0);
        chk_outs(p, r, hi, c, z, n, v, e);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            bus.i_ready  = 1'b0;
            bus.i_valid  = 1'($urandom);
            bus.i_a      = W'($urandom);
            bus.i_b      = W'($urandom);
            bus.i_opcode = 3'($urandom);
            @(negedge clk);
            chk({p, "_stall_valid"}, bus.o_valid, 1);
            chk({p, "_stall_ready"}, bus.o_ready, 0);
            chk_outs({p, "_stall"}, r, hi, c, z, n, v, e);
        end
        @(negedge clk);
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({p, "_rel_valid"}, bus.o_valid, 0);
        chk({p, "_rel_ready"}, bus.o_ready, 1);
        @(negedge clk);
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b0;
    endtask

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_ready  = 1'b0;
        bus.i_opcode = '0;
        bus.i_a      = '0;
        bus.i_b      = '0;
        #3;
        chk("rst_ready", bus.o_ready, 1);
        chk("rst_valid", bus.o_valid, 0);
        chk_outs("rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_9_8",  0, 9,  8, 0);
        run_op("sub_3_5",  1, 3,  5, 0);
        run_op("sub_5_5",  1, 5,  5, 0);
        run_op("shl_11_1", 5, 11, 1, 0);
        run_op("shr_11_2", 6, 11, 2, 0);
        run_op("shr_11_0", 6, 11, 0, 0);
        run_op("mul_15_15", 7, 15, 15, 0);
        run_op("and_12_10", 2, 12, 10, 0);
        run_op("or_12_10",  3, 12, 10, 0);
        run_op("xor_12_10", 4, 12, 10, 0);
        run_op("bp_add",    0, 7,  1, 10);

        // Async reset two cycles into a multiply (DONE in non-MUL builds).
        bus.i_valid  = 1'b1;
        bus.i_opcode = 3'd7;
        bus.i_a      = W'(15);
        bus.i_b      = W'(15);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", bus.o_ready, 1);
        chk("mrst_valid", bus.o_valid, 0);
        chk_outs("mrst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst_add", 0, 2, 3, 0);

        for (int i = 0; i < 150; i++) begin
            run_op($sformatf("rnd%0d", i), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, FULL - 1)),
                   int'($urandom_range(0, FULL - 1)),
                   int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
